// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  router_pkg
//  Shared types and header layout for the router port reader.
//  Revision: 1.0
// ============================================================================
package router_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    HDR_RD  = 3'd2,
    HDR_CAP = 3'd3,
    BODY    = 3'd4,
    DONE    = 3'd5
  } rpr_state_t;

  localparam int unsigned MAX_PAYLOAD     = 63;
  localparam int unsigned SOFT_RST_CYCLES = 30;

  localparam int unsigned LEN_MSB  = 7;
  localparam int unsigned LEN_LSB  = 2;
  localparam int unsigned ADDR_MSB = 1;

  // Holds header + MAX_PAYLOAD + parity read count
  localparam int unsigned RPR_RD_W = $clog2(MAX_PAYLOAD + 3);

  // Reads issued in BODY: payload bytes plus the trailing parity byte
  function automatic logic [RPR_RD_W-1:0] rpr_body_reads(input logic [5:0] len);
    return RPR_RD_W'(len) + RPR_RD_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_parity_acc.sv
`default_nettype none
// ============================================================================
//  router_parity_acc
//  Running XOR accumulator with clear/accumulate and compare against a byte.
//  Revision: 1.0
// ============================================================================
module router_parity_acc (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       acc_i,
  input  logic [7:0] data_i,
  output logic       match_o
);

  logic [7:0] acc_q, acc_d;

  // clr and acc together load data_i directly (header byte)
  always_comb begin
    acc_d = acc_q;
    if (clr_i) acc_d = 8'h00;
    if (acc_i) acc_d = acc_d ^ data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= 8'h00;
    else        acc_q <= acc_d;
  end

  assign match_o = (acc_q == data_i);

endmodule
`default_nettype wire

// File: rtl/router_port_reader.sv
`default_nettype none
// ============================================================================
//  router_port_reader
//  Drains one router output port FIFO, streams bytes and reports packet status.
//  Optional statistics counters: define ROUTER_PORT_READER_STATS_EN.
//  Revision: 1.0
// ============================================================================
module router_port_reader
  import router_pkg::*;
#(
  parameter int unsigned PORT_ID    = 0,
  parameter int unsigned READ_DELAY = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vld_out,
  input  logic [7:0]  dout,
  output logic        rd_en,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_sop,
  output logic        o_eop,
  output logic        pkt_done,
  output logic        pkt_err,
  output logic        pkt_abort,
  output logic [5:0]  pkt_len,
  output logic [1:0]  pkt_addr
`ifdef ROUTER_PORT_READER_STATS_EN
  ,
  output logic [15:0] pkt_cnt,
  output logic [15:0] err_cnt,
  output logic [15:0] abort_cnt
`endif
);

  // Header read must land well inside the router's soft-reset window
  localparam int unsigned DLY_MAX =
      (READ_DELAY > SOFT_RST_CYCLES - 5) ? SOFT_RST_CYCLES - 5 : READ_DELAY;
  localparam int unsigned IW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT);
  localparam logic [4:0]    DLY_LIMIT  = 5'(DLY_MAX);
  localparam logic [1:0]    MY_ADDR    = 2'(PORT_ID);

  rpr_state_t          state_q, state_d;
  logic [4:0]          dly_q, dly_d;
  logic [RPR_RD_W-1:0] reads_q, reads_d;
  logic [IW-1:0]       idle_q, idle_d;
  logic [5:0]          len_q, len_d;
  logic [1:0]          addr_q, addr_d;
  logic                err_q, err_d;
  logic                abort_q, abort_d;
  logic                rd_q;

  logic body_more;
  logic last_cap;
  logic par_clr;
  logic par_acc;
  logic par_match;

  assign body_more = (reads_q < rpr_body_reads(len_q));
  // The in-flight read is always the most recently issued one
  assign last_cap  = (state_q == BODY) && rd_q && (reads_q == rpr_body_reads(len_q));
  assign rd_en     = vld_out && ((state_q == HDR_RD) || ((state_q == BODY) && body_more));

  assign par_clr = (state_q == HDR_CAP);
  assign par_acc = ((state_q == HDR_CAP) && rd_q) || ((state_q == BODY) && rd_q && !last_cap);

  router_parity_acc u_parity (
    .clk     (clk),
    .rst_n   (rst),
    .clr_i   (par_clr),
    .acc_i   (par_acc),
    .data_i  (dout),
    .match_o (par_match)
  );

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    reads_d = reads_q;
    idle_d  = idle_q;
    len_d   = len_q;
    addr_d  = addr_q;
    err_d   = err_q;
    abort_d = abort_q;
    unique case (state_q)
      IDLE: begin
        dly_d   = '0;
        reads_d = '0;
        idle_d  = '0;
        err_d   = 1'b0;
        abort_d = 1'b0;
        if (vld_out) state_d = (DLY_MAX == 0) ? HDR_RD : WAIT;
      end
      WAIT: begin
        if (!vld_out)               state_d = IDLE;
        else if (dly_q == DLY_LIMIT) state_d = HDR_RD;
        else                        dly_d   = dly_q + 5'd1;
      end
      HDR_RD: begin
        if (vld_out) state_d = HDR_CAP;
      end
      HDR_CAP: begin
        len_d   = dout[LEN_MSB:LEN_LSB];
        addr_d  = dout[ADDR_MSB:0];
        reads_d = '0;
        idle_d  = '0;
        state_d = BODY;
      end
      BODY: begin
        if (rd_en) begin
          reads_d = reads_q + RPR_RD_W'(1);
          idle_d  = '0;
        end else if (body_more) begin
          idle_d  = idle_q + IW'(1);
        end
        if (last_cap) begin
          err_d   = !par_match || (addr_q != MY_ADDR);
          state_d = DONE;
        end else if (!rd_q && (idle_q == IDLE_LIMIT)) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dly_q   <= '0;
      reads_q <= '0;
      idle_q  <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      reads_q <= reads_d;
      idle_q  <= idle_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      rd_q    <= rd_en;
    end
  end

  assign o_valid   = rd_q && ((state_q == HDR_CAP) || (state_q == BODY));
  assign o_data    = o_valid ? dout : 8'h00;
  assign o_sop     = rd_q && (state_q == HDR_CAP);
  assign o_eop     = last_cap;
  assign pkt_done  = (state_q == DONE);
  assign pkt_err   = (state_q == DONE) && err_q;
  assign pkt_abort = (state_q == DONE) && abort_q;
  assign pkt_len   = len_q;
  assign pkt_addr  = addr_q;

`ifdef ROUTER_PORT_READER_STATS_EN
  logic [15:0] pkt_cnt_q, err_cnt_q, abort_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt_q   <= 16'h0000;
      err_cnt_q   <= 16'h0000;
      abort_cnt_q <= 16'h0000;
    end else if (state_q == DONE) begin
      if (pkt_cnt_q != 16'hFFFF)              pkt_cnt_q   <= pkt_cnt_q + 16'd1;
      if (err_q && (err_cnt_q != 16'hFFFF))   err_cnt_q   <= err_cnt_q + 16'd1;
      if (abort_q && (abort_cnt_q != 16'hFFFF)) abort_cnt_q <= abort_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt   = pkt_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign abort_cnt = abort_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_router_port_reader.sv
`default_nettype none
// ============================================================================
//  tb_router_port_reader
//  Scoreboard bench: FIFO model drives the port, expected bytes/status queued.
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_router_port_reader;

  localparam int unsigned PORT_ID    = 1;
  localparam int unsigned READ_DELAY = 4;
  localparam int unsigned TIMEOUT    = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vld_out;
  logic [7:0] dout;
  logic       rd_en;
  logic [7:0] o_data;
  logic       o_valid, o_sop, o_eop;
  logic       pkt_done, pkt_err, pkt_abort;
  logic [5:0] pkt_len;
  logic [1:0] pkt_addr;
`ifdef ROUTER_PORT_READER_STATS_EN
  logic [15:0] pkt_cnt, err_cnt, abort_cnt;
`endif

  router_port_reader #(
    .PORT_ID    (PORT_ID),
    .READ_DELAY (READ_DELAY),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .vld_out   (vld_out),
    .dout      (dout),
    .rd_en     (rd_en),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_sop     (o_sop),
    .o_eop     (o_eop),
    .pkt_done  (pkt_done),
    .pkt_err   (pkt_err),
    .pkt_abort (pkt_abort),
    .pkt_len   (pkt_len),
    .pkt_addr  (pkt_addr)
`ifdef ROUTER_PORT_READER_STATS_EN
    ,
    .pkt_cnt   (pkt_cnt),
    .err_cnt   (err_cnt),
    .abort_cnt (abort_cnt)
`endif
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_bad = 0;
  logic [7:0] fifo[$];
  logic [9:0] exp_byte[$];   // {sop, eop, data}
  logic [9:0] exp_stat[$];   // {err, abort, len, addr}
  int         nreads   = 0;
  int         done_cnt = 0;
  logic       stall    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Port FIFO model: data appears the cycle after a read strobe
  initial begin : fifo_drv
    logic rd_seen;
    vld_out = 1'b0;
    dout    = 8'h00;
    forever begin
      @(negedge clk);
      rd_seen = rd_en;
      @(posedge clk);
      #1;
      if (rd_seen && (fifo.size() > 0)) begin
        dout = fifo.pop_front();
        nreads++;
      end
      vld_out = (fifo.size() > 0) && !stall;
    end
  end

  initial begin : monitor
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (o_valid) begin
          if (exp_byte.size() == 0) check("stray_byte", 32'(o_valid), 32'd0);
          else begin
            e = exp_byte.pop_front();
            check("byte", {22'd0, o_sop, o_eop, o_data}, {22'd0, e});
          end
        end
        if (pkt_done) begin
          done_cnt++;
          if (exp_stat.size() == 0) check("stray_done", 32'(pkt_done), 32'd0);
          else begin
            e = exp_stat.pop_front();
            check("status", {22'd0, pkt_err, pkt_abort, pkt_len, pkt_addr}, {22'd0, e});
          end
        end
      end
    end
  end

  // Queue one packet into the FIFO and its expectations into the scoreboard
  task automatic load_pkt(input logic [7:0] hdr, input logic [7:0] seed, input int bad_par,
                          input int trunc, output int exp_reads);
    logic [5:0] len;
    logic [7:0] par, b;
    logic       err, abort;
    int         nbody;
    len   = hdr[7:2];
    par   = hdr;
    abort = (trunc > 0);
    nbody = abort ? trunc : int'(len);
    nreads = 0;
    fifo.push_back(hdr);
    exp_byte.push_back({2'b10, hdr});
    for (int i = 0; i < nbody; i++) begin
      b   = 8'((i + 1) * seed);
      par = par ^ b;
      fifo.push_back(b);
      exp_byte.push_back({2'b00, b});
    end
    if (!abort) begin
      b = (bad_par >= 0) ? 8'(bad_par) : par;
      fifo.push_back(b);
      exp_byte.push_back({2'b01, b});
    end
    err = abort || ((bad_par >= 0) && (8'(bad_par) != par)) || (hdr[1:0] != 2'(PORT_ID));
    exp_stat.push_back({err, abort, len, hdr[1:0]});
    exp_reads = abort ? 1 + trunc : int'(len) + 2;
  endtask

  task automatic send(input logic [7:0] hdr, input logic [7:0] seed, input int bad_par,
                      input int stall_at, input int stall_cyc, input int trunc);
    int exp_reads, lat, d0, wc;
    @(posedge clk);
    #2;
    d0 = done_cnt;
    load_pkt(hdr, seed, bad_par, trunc, exp_reads);
    @(posedge clk);
    #2;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      if (rd_en) break;
      lat++;
    end
    check("first_rd_latency", 32'(lat), 32'(READ_DELAY + 2));
    if (stall_at > 0) begin
      wc = 0;
      while ((nreads < stall_at + 1) && (wc < 500)) begin
        @(posedge clk);
        wc++;
      end
      stall = 1'b1;
      repeat (stall_cyc) @(posedge clk);
      stall = 1'b0;
    end
    wc = 0;
    while ((done_cnt == d0) && (wc < 1000)) begin
      @(posedge clk);
      wc++;
    end
    check("pkt_done_seen", 32'(done_cnt - d0), 32'd1);
    @(negedge clk);
    check("reads", 32'(nreads), 32'(exp_reads));
    check("bytes_left", 32'(exp_byte.size()), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int exp_reads, d0, wc;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {rd_en, o_valid, o_sop, o_eop, pkt_done, pkt_err, pkt_abort,
                            o_data, pkt_len, pkt_addr}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    send(8'h0D, 8'h11, -1, 0, 0, 0);     // len 3, good parity, matching addr
    send(8'h0D, 8'h11, 0,  0, 0, 0);     // parity byte forced to 00
    send(8'h06, 8'h11, -1, 0, 0, 0);     // addr 2 on port 1
    send(8'h0C, 8'h11, -1, 0, 0, 0);     // addr 0 on port 1
    send(8'hFD, 8'h07, -1, 20, 10, 0);   // max length, 10-cycle stall
    send(8'h01, 8'h00, -1, 0, 0, 0);     // len 0: parity byte only
    send(8'h29, 8'h03, -1, 0, 0, 4);     // starve after 4 payload bytes
    send(8'h09, 8'h05, -1, 0, 0, 0);     // clean packet after abort

    // Reset in the middle of a packet
    @(posedge clk);
    #2;
    d0 = done_cnt;
    load_pkt(8'h21, 8'h05, -1, 0, exp_reads);
    wc = 0;
    while ((nreads < 5) && (wc < 200)) begin
      @(posedge clk);
      wc++;
    end
    check("reads_before_rst", 32'(nreads >= 5), 32'd1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_mid_outputs", {rd_en, o_valid, o_sop, o_eop, pkt_done, pkt_err, pkt_abort,
                              o_data, pkt_len, pkt_addr}, 32'd0);
    fifo.delete();
    exp_byte.delete();
    exp_stat.delete();
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    check("no_done_on_rst", 32'(done_cnt - d0), 32'd0);
    send(8'h11, 8'h09, -1, 0, 0, 0);     // len 4, clean after reset

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
